// File: rtl/tt_sel_ctrl.sv
// tt_sel_ctrl: sequencing controller at the top of the row-mux spine.
// Converts three slow, asynchronous control pins into the spine select bus
// and spine enable. Any change of select is bracketed by quiet phases so a
// row mux never sees its select move while it is enabled.
module tt_sel_ctrl #(
   parameter int N_DESIGNS = 1024,
   parameter int GUARD     = 4,
   parameter int PEND_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ctrl_sel_inc,
   input  logic       ctrl_sel_rst_n,
   input  logic       ctrl_ena,
   output logic [9:0] spine_sel,
   output logic       spine_ena,
   output logic [9:0] cur_sel,
   output logic       busy
);

   localparam int IDX_W = 10;
   localparam int CNT_W = 4;

   localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_DESIGNS - 1);
   localparam logic [PEND_W-1:0] PEND_MAX   = '1;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      QUIESCE = 2'd1,
      SWITCH  = 2'd2
   } state_t;

   // Pin synchronizers and edge-detect history
   logic inc_s1_q, inc_s2_q, inc_dly_q;
   logic rsn_s1_q, rsn_s2_q;
   logic ena_s1_q, ena_s2_q;
   logic inc_evt_q, inc_evt_d;

   // Sequencer state
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   cur_sel_q, cur_sel_d;
   logic [PEND_W-1:0]  pending_q, pending_d;
   logic               spine_ena_q, spine_ena_d;

   logic rst_req;
   logic ena_sync;
   logic work_left;
   logic commit;
   logic dec;

   // Synchronized pin levels; the select-reset pin is active low at the pin
   assign rst_req  = ~rsn_s2_q;
   assign ena_sync = ena_s2_q;

   // Two-flop synchronizers plus the delayed copy used for inc edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inc_s1_q  <= 1'b0;
         inc_s2_q  <= 1'b0;
         inc_dly_q <= 1'b0;
         rsn_s1_q  <= 1'b0;
         rsn_s2_q  <= 1'b0;
         ena_s1_q  <= 1'b0;
         ena_s2_q  <= 1'b0;
         inc_evt_q <= 1'b0;
      end else begin
         inc_s1_q  <= ctrl_sel_inc;
         inc_s2_q  <= inc_s1_q;
         inc_dly_q <= inc_s2_q;
         rsn_s1_q  <= ctrl_sel_rst_n;
         rsn_s2_q  <= rsn_s1_q;
         ena_s1_q  <= ctrl_ena;
         ena_s2_q  <= ena_s1_q;
         inc_evt_q <= inc_evt_d;
      end
   end

   // Registered one-cycle pulse on each synchronized rising edge of the inc pin
   always_comb begin
      inc_evt_d = inc_s2_q & ~inc_dly_q;
   end

   // Sequencer, pending counter and index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         cur_sel_q   <= '0;
         pending_q   <= '0;
         spine_ena_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_sel_q   <= cur_sel_d;
         pending_q   <= pending_d;
         spine_ena_q <= spine_ena_d;
      end
   end

   // Next-state: RUN -> QUIESCE -> SWITCH (commit on entry) -> RUN or QUIESCE
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_sel_d   = cur_sel_q;
      pending_d   = pending_q;
      spine_ena_d = 1'b0;
      commit      = 1'b0;
      dec         = 1'b0;
      work_left   = (pending_q != '0) || (rst_req && (cur_sel_q != '0));

      case (state_q)
         RUN: begin
            if (work_left) begin
               state_d = QUIESCE;
               cnt_d   = GUARD_LAST;
            end
         end
         QUIESCE: begin
            if (cnt_q == '0) begin
               state_d = SWITCH;
               cnt_d   = GUARD_LAST;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SWITCH: begin
            if (cnt_q == '0) begin
               // Chain straight into another quiet phase if work remains,
               // so the spine is not briefly re-enabled between switches.
               if (work_left) begin
                  state_d = QUIESCE;
                  cnt_d   = GUARD_LAST;
               end else begin
                  state_d = RUN;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase

      // A select reset overrides queued increments. An increment commit only
      // happens when one is actually queued (a reset request may have been
      // withdrawn while quiescing, leaving nothing to do).
      if (commit) begin
         if (rst_req) begin
            cur_sel_d = '0;
         end else if (pending_q != '0) begin
            dec       = 1'b1;
            cur_sel_d = (cur_sel_q == LAST_IDX) ? '0 : cur_sel_q + 1'b1;
         end
      end

      if (rst_req) begin
         pending_d = '0;
      end else if (inc_evt_q && !dec) begin
         if (pending_q != PEND_MAX) begin
            pending_d = pending_q + 1'b1;
         end
      end else if (dec && !inc_evt_q) begin
         pending_d = pending_q - 1'b1;
      end

      // The enable is only ever driven while the controller will be in RUN
      if (state_d == RUN) begin
         spine_ena_d = ena_sync;
      end
   end

   // Spine select: branch/local interleave of the linear index
   assign spine_sel = {cur_sel_q[9:6], cur_sel_q[0], cur_sel_q[5], cur_sel_q[4:1]};
   assign spine_ena = spine_ena_q;
   assign cur_sel   = cur_sel_q;
   assign busy      = (state_q != RUN);

endmodule

// File: tb/tb_tt_sel_ctrl.sv
// Directed bench for tt_sel_ctrl: a default instance (1024 designs) and a
// small instance (8 designs) for the wrap and select-reset scenarios.
module tb_tt_sel_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic       inc_a = 1'b0, srst_a = 1'b1, ena_a = 1'b1;
   logic [9:0] sel_a, cur_a;
   logic       eno_a, busy_a;

   logic       inc_b = 1'b0, srst_b = 1'b1, ena_b = 1'b1;
   logic [9:0] sel_b, cur_b;
   logic       eno_b, busy_b;

   logic       use8 = 1'b0;
   logic [9:0] mon_sel, mon_cur;
   logic       mon_ena, mon_busy;

   int checks = 0;
   int failures = 0;

   int edge_cnt, n_low, n_commit, n_rise, first_low, commit_edge, overlap;
   logic [9:0] prev_sel, prev_cur;
   logic       prev_ena;

   tt_sel_ctrl #(.N_DESIGNS(1024), .GUARD(4), .PEND_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ctrl_sel_inc(inc_a), .ctrl_sel_rst_n(srst_a), .ctrl_ena(ena_a),
      .spine_sel(sel_a), .spine_ena(eno_a), .cur_sel(cur_a), .busy(busy_a)
   );

   tt_sel_ctrl #(.N_DESIGNS(8), .GUARD(4), .PEND_W(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .ctrl_sel_inc(inc_b), .ctrl_sel_rst_n(srst_b), .ctrl_ena(ena_b),
      .spine_sel(sel_b), .spine_ena(eno_b), .cur_sel(cur_b), .busy(busy_b)
   );

   assign mon_sel  = use8 ? sel_b  : sel_a;
   assign mon_cur  = use8 ? cur_b  : cur_a;
   assign mon_ena  = use8 ? eno_b  : eno_a;
   assign mon_busy = use8 ? busy_b : busy_a;

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic set_inc(input logic v);
      if (use8) inc_b = v;
      else      inc_a = v;
   endtask

   task automatic reset_stats();
      edge_cnt = 0; n_low = 0; n_commit = 0; n_rise = 0;
      first_low = 0; commit_edge = 0; overlap = 0;
      prev_sel = mon_sel; prev_cur = mon_cur; prev_ena = mon_ena;
   endtask

   // Advance one clock, sample just after the edge and update the statistics
   task automatic sample_cycle();
      @(posedge clk);
      #1;
      edge_cnt++;
      if (mon_cur != prev_cur) begin
         n_commit++;
         if (commit_edge == 0) commit_edge = edge_cnt;
      end
      if ((mon_sel != prev_sel) && (mon_ena || prev_ena)) overlap++;
      if (mon_ena && mon_busy) overlap++;
      if (!mon_ena) begin
         n_low++;
         if (first_low == 0) first_low = edge_cnt;
      end
      if (mon_ena && !prev_ena) n_rise++;
      prev_sel = mon_sel; prev_cur = mon_cur; prev_ena = mon_ena;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) sample_cycle();
   endtask

   // Issue n inc pulses (2 high, 2 low) then wait until the controller is idle
   task automatic burst(input int n);
      for (int p = 0; p < n; p++) begin
         set_inc(1'b1);
         sample_cycle();
         sample_cycle();
         set_inc(1'b0);
         sample_cycle();
         sample_cycle();
      end
      sample_cycle();
      sample_cycle();
      for (int i = 0; i < 400; i++) begin
         if (!mon_busy) break;
         sample_cycle();
      end
      checks++;
      if (mon_busy !== 1'b0) begin
         failures++;
         $display("FAIL burst_idle_timeout busy=%0b exp=0", mon_busy);
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++; if (cur_a !== 10'd0) begin failures++; $display("FAIL rst_cur got=%0d exp=0", cur_a); end
      checks++; if (sel_a !== 10'h000) begin failures++; $display("FAIL rst_sel got=%h exp=000", sel_a); end
      checks++; if (eno_a !== 1'b0) begin failures++; $display("FAIL rst_ena got=%0b exp=0", eno_a); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy_a); end
      rst_n = 1'b1;
      reset_stats();
      sample_cycle();
      sample_cycle();
      checks++; if (eno_a !== 1'b0) begin failures++; $display("FAIL rel_ena_c2 got=%0b exp=0", eno_a); end
      sample_cycle();
      checks++; if (eno_a !== 1'b1) begin failures++; $display("FAIL rel_ena_c3 got=%0b exp=1", eno_a); end
      checks++; if (cur_a !== 10'd0) begin failures++; $display("FAIL rel_cur got=%0d exp=0", cur_a); end
      checks++; if (sel_a !== 10'h000) begin failures++; $display("FAIL rel_sel got=%h exp=000", sel_a); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rel_busy got=%0b exp=0", busy_a); end
   endtask

   task automatic test_enable();
      ena_a = 1'b0;
      sample_cycle();
      sample_cycle();
      checks++; if (eno_a !== 1'b1) begin failures++; $display("FAIL ena_off_c2 got=%0b exp=1", eno_a); end
      sample_cycle();
      checks++; if (eno_a !== 1'b0) begin failures++; $display("FAIL ena_off_c3 got=%0b exp=0", eno_a); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL ena_busy got=%0b exp=0", busy_a); end
      ena_a = 1'b1;
      for (int i = 0; i < 3; i++) sample_cycle();
      checks++; if (eno_a !== 1'b1) begin failures++; $display("FAIL ena_on got=%0b exp=1", eno_a); end
      checks++; if (cur_a !== 10'd0) begin failures++; $display("FAIL ena_cur got=%0d exp=0", cur_a); end
   endtask

   task automatic test_single_inc();
      reset_stats();
      set_inc(1'b1);
      sample_cycle();
      sample_cycle();
      set_inc(1'b0);
      for (int i = 0; i < 18; i++) sample_cycle();
      checks++; if (first_low !== 5) begin failures++; $display("FAIL single_first_low got=%0d exp=5", first_low); end
      checks++; if (n_low !== 8) begin failures++; $display("FAIL single_low_cycles got=%0d exp=8", n_low); end
      checks++; if (commit_edge !== 9) begin failures++; $display("FAIL single_commit_edge got=%0d exp=9", commit_edge); end
      checks++; if (n_commit !== 1) begin failures++; $display("FAIL single_commits got=%0d exp=1", n_commit); end
      checks++; if (cur_a !== 10'd1) begin failures++; $display("FAIL single_cur got=%0d exp=1", cur_a); end
      checks++; if (sel_a !== 10'h020) begin failures++; $display("FAIL single_sel got=%h exp=020", sel_a); end
      checks++; if (eno_a !== 1'b1) begin failures++; $display("FAIL single_ena_back got=%0b exp=1", eno_a); end
      checks++; if (overlap !== 0) begin failures++; $display("FAIL single_overlap got=%0d exp=0", overlap); end
   endtask

   task automatic test_encoding();
      logic [4:0] branch, local_idx;
      burst(14);
      burst(14);
      burst(4);
      checks++; if (cur_a !== 10'd33) begin failures++; $display("FAIL enc33_cur got=%0d exp=33", cur_a); end
      checks++; if (sel_a !== 10'h030) begin failures++; $display("FAIL enc33_sel got=%h exp=030", sel_a); end
      burst(1);
      branch    = {sel_a[9:6], sel_a[4]};
      local_idx = {sel_a[3:0], sel_a[5]};
      checks++; if (cur_a !== 10'd34) begin failures++; $display("FAIL enc34_cur got=%0d exp=34", cur_a); end
      checks++; if (sel_a !== 10'h011) begin failures++; $display("FAIL enc34_sel got=%h exp=011", sel_a); end
      checks++; if (branch !== 5'd1) begin failures++; $display("FAIL enc34_branch got=%0d exp=1", branch); end
      checks++; if (local_idx !== 5'd2) begin failures++; $display("FAIL enc34_local got=%0d exp=2", local_idx); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      reset_stats();
      for (int p = 0; p < 5; p++) begin
         set_inc(1'b1);
         sample_cycle();
         set_inc(1'b0);
         sample_cycle();
      end
      for (int i = 0; i < 50; i++) sample_cycle();
      checks++; if (n_commit !== 5) begin failures++; $display("FAIL b2b_commits got=%0d exp=5", n_commit); end
      checks++; if (cur_a !== 10'd5) begin failures++; $display("FAIL b2b_cur got=%0d exp=5", cur_a); end
      checks++; if (n_low !== 40) begin failures++; $display("FAIL b2b_low_cycles got=%0d exp=40", n_low); end
      checks++; if (n_rise !== 1) begin failures++; $display("FAIL b2b_reenables got=%0d exp=1", n_rise); end
      checks++; if (first_low !== 5) begin failures++; $display("FAIL b2b_first_low got=%0d exp=5", first_low); end
      checks++; if (overlap !== 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=0", overlap); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%0b exp=0", busy_a); end
   endtask

   task automatic test_wrap_and_sel_rst();
      use8 = 1'b1;
      apply_reset();
      burst(7);
      checks++; if (cur_b !== 10'd7) begin failures++; $display("FAIL wrap_pre_cur got=%0d exp=7", cur_b); end
      checks++; if (sel_b !== 10'h023) begin failures++; $display("FAIL wrap_pre_sel got=%h exp=023", sel_b); end
      burst(1);
      checks++; if (cur_b !== 10'd0) begin failures++; $display("FAIL wrap_cur got=%0d exp=0", cur_b); end
      checks++; if (sel_b !== 10'h000) begin failures++; $display("FAIL wrap_sel got=%h exp=000", sel_b); end
      burst(5);
      checks++; if (cur_b !== 10'd5) begin failures++; $display("FAIL srst_pre_cur got=%0d exp=5", cur_b); end
      reset_stats();
      for (int p = 0; p < 3; p++) begin
         set_inc(1'b1);
         sample_cycle();
         set_inc(1'b0);
         sample_cycle();
      end
      srst_b = 1'b0;
      for (int i = 0; i < 19; i++) sample_cycle();
      checks++; if (n_commit !== 1) begin failures++; $display("FAIL srst_commits got=%0d exp=1", n_commit); end
      checks++; if (commit_edge !== 9) begin failures++; $display("FAIL srst_commit_edge got=%0d exp=9", commit_edge); end
      checks++; if (n_low !== 8) begin failures++; $display("FAIL srst_low_cycles got=%0d exp=8", n_low); end
      checks++; if (cur_b !== 10'd0) begin failures++; $display("FAIL srst_cur got=%0d exp=0", cur_b); end
      checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL srst_busy got=%0b exp=0", busy_b); end
      checks++; if (overlap !== 0) begin failures++; $display("FAIL srst_overlap got=%0d exp=0", overlap); end
      srst_b = 1'b1;
      for (int i = 0; i < 3; i++) sample_cycle();
      use8 = 1'b0;
   endtask

   task automatic test_rst_mid_switch();
      reset_stats();
      set_inc(1'b1);
      sample_cycle();
      sample_cycle();
      set_inc(1'b0);
      for (int i = 0; i < 8; i++) sample_cycle();
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL mid_pre_busy got=%0b exp=1", busy_a); end
      checks++; if (cur_a !== 10'd1) begin failures++; $display("FAIL mid_pre_cur got=%0d exp=1", cur_a); end
      rst_n = 1'b0;
      #1;
      checks++; if (cur_a !== 10'd0) begin failures++; $display("FAIL mid_rst_cur got=%0d exp=0", cur_a); end
      checks++; if (sel_a !== 10'h000) begin failures++; $display("FAIL mid_rst_sel got=%h exp=000", sel_a); end
      checks++; if (eno_a !== 1'b0) begin failures++; $display("FAIL mid_rst_ena got=%0b exp=0", eno_a); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0b exp=0", busy_a); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      reset_stats();
      for (int i = 0; i < 20; i++) sample_cycle();
      checks++; if (n_commit !== 0) begin failures++; $display("FAIL mid_after_commits got=%0d exp=0", n_commit); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL mid_after_busy got=%0b exp=0", busy_a); end
      checks++; if (cur_a !== 10'd0) begin failures++; $display("FAIL mid_after_cur got=%0d exp=0", cur_a); end
      checks++; if (eno_a !== 1'b1) begin failures++; $display("FAIL mid_after_ena got=%0b exp=1", eno_a); end
   endtask

   initial begin
      test_reset();
      test_enable();
      test_single_inc();
      test_encoding();
      test_back_to_back();
      test_wrap_and_sel_rst();
      test_rst_mid_switch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
